// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, redirect kinds, queue entry type and redirect target helper
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [1:0] REDIR_NONE = 2'b00;
   localparam logic [1:0] REDIR_BRANCH = 2'b01;
   localparam logic [1:0] REDIR_JUMP = 2'b10;
   localparam logic [1:0] REDIR_JR = 2'b11;
   typedef struct packed {
      logic [INSTR_W-1:0] instruction;
      logic [ADDR_W-1:0] pc;
      logic [ADDR_W-1:0] pc_plus4;
   } fetch_entry_t;
   function automatic logic [ADDR_W-1:0] redirect_target(
      input logic [1:0] kind,
      input logic [ADDR_W-1:0] pc,
      input logic [25:0] imm,
      input logic [ADDR_W-1:0] rs
   );
      logic [ADDR_W-1:0] pc4;
      pc4 = pc + ADDR_W'(4);
      return kind == REDIR_JR ? rs :
             kind == REDIR_JUMP ? {pc4[ADDR_W-1:28], imm, 2'b00} :
             pc4 + {{14{imm[15]}}, imm[15:0], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: flushable circular FIFO of fetch entries with full/empty and head data
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic         i_pop,
   input  fetch_entry_t i_data,
   output fetch_entry_t o_head,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);
   fetch_entry_t r_mem [DEPTH];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [AW:0] r_count;
   // entry storage; no reset needed because the head is masked to zero while empty
   always_ff @(posedge clk) begin
      if (i_push && !i_flush && !rst) r_mem[r_wr] <= i_data;
   end
   // wrapping pointers and occupancy; reset and flush both empty the queue
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_rd <= '0;
         r_wr <= '0;
         r_count <= '0;
      end else begin
         r_wr <= r_wr + AW'(i_push);
         r_rd <= r_rd + AW'(i_pop);
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end
   assign o_full = r_count == (AW+1)'(DEPTH);
   assign o_empty = r_count == '0;
   assign o_head = o_empty ? '0 : r_mem[r_rd];
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, next-PC/redirect logic and the decode-facing fetch queue
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets with a sticky fetch_error.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int QUEUE_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  imem_address,
   input  logic [INSTR_W-1:0] imem_instruction,
   input  logic               halt,
   input  logic [1:0]         redirect_kind,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic [25:0]        redirect_imm,
   input  logic [ADDR_W-1:0]  redirect_reg,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instruction,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [ADDR_W-1:0]  out_pc_plus4,
   output logic               fetch_error
);
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_raw_target;
   logic [ADDR_W-1:0] w_target;
   logic w_redir;
   logic w_pop;
   logic w_push;
   logic w_full;
   logic w_empty;
   fetch_entry_t w_entry;
   fetch_entry_t w_head;
   assign imem_address = r_pc;
   assign w_redir = redirect_kind != REDIR_NONE;
   assign w_pop = out_valid && out_ready;
   assign w_push = !halt && !w_redir && !fetch_error && (!w_full || w_pop);
   assign w_raw_target = redirect_target(redirect_kind, redirect_pc, redirect_imm, redirect_reg);
`ifdef FETCH_MISALIGN_TRAP_EN
   logic r_error;
   // any misaligned redirect latches the trap until reset
   always_ff @(posedge clk) begin
      if (rst) r_error <= 1'b0;
      else if (w_redir && w_raw_target[1:0] != 2'b00) r_error <= 1'b1;
   end
   assign w_target = w_raw_target;
   assign fetch_error = r_error;
`else
   assign w_target = w_raw_target & ~ADDR_W'(3);
   assign fetch_error = 1'b0;
`endif
   // program counter: redirect wins over sequential advance; halt simply blocks the push
   always_ff @(posedge clk) begin
      if (rst) r_pc <= RESET_PC;
      else if (w_redir) r_pc <= w_target;
      else if (w_push) r_pc <= r_pc + ADDR_W'(4);
   end
   assign w_entry = '{instruction: imem_instruction, pc: r_pc, pc_plus4: r_pc + ADDR_W'(4)};
   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk(clk),
      .rst(rst),
      .i_flush(w_redir),
      .i_push(w_push),
      .i_pop(w_pop),
      .i_data(w_entry),
      .o_head(w_head),
      .o_full(w_full),
      .o_empty(w_empty)
   );
   assign out_valid = !w_empty;
   assign out_instruction = w_head.instruction;
   assign out_pc = w_head.pc;
   assign out_pc_plus4 = w_head.pc_plus4;
endmodule
